multi_edge_detect: RTL and testbench

Parametrised multi-channel edge detector, successor to the single-bit edge detector. Each channel passes through:
- an N-stage input synchroniser,
- a stability (glitch) filter,
- rising/falling edge detection with a per-channel mode select,
- a sticky event flag and a saturating event counter.
Sits between asynchronous pins or slow control inputs and interrupt/status logic.

---
 rtl/multi_edge_detect.sv | 130 +++++++++++++
 tb/tb_multi_edge_detect.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: synchroniser, optional glitch filter (enabled by
// MULTI_EDGE_GLITCH_FILTER_EN), mode-gated edge pulses, sticky flags and saturating counters.
module multi_edge_detect #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         data_in,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH-1:0]         clr,
    output logic [CH-1:0]         data_filt,
    output logic [CH-1:0]         pos_edge,
    output logic [CH-1:0]         neg_edge,
    output logic [CH-1:0]         edge_pulse,
    output logic [CH-1:0]         edge_sticky,
    output logic [CH*CNT_W-1:0]   edge_cnt,
    output logic                  any_edge
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (CH < 1 || SYNC_STAGES < 1 || FILT_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("multi_edge_detect: all parameters must be >= 1");
    end

    logic [SYNC_STAGES-1:0][CH-1:0] sync_r;
    logic [CH-1:0]                  sync_out_s;
    logic [CH-1:0]                  filt_r;
    logic [CH-1:0]                  filt_d_r;
    logic [CH-1:0]                  sticky_r;
    logic [CH-1:0][CNT_W-1:0]       cnt_r;

    // Synchroniser shift chain; stage 0 is the only flop that sees raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= data_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_out_s = sync_r[SYNC_STAGES-1];

`ifdef MULTI_EDGE_GLITCH_FILTER_EN
    localparam int             FW        = $clog2(FILT_CYCLES + 1);
    localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_CYCLES - 1);

    logic [CH-1:0][FW-1:0] filt_cnt_r;

    // Stability filter: a new level must persist FILT_CYCLES cycles; any return drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_r <= '0;
            filt_r     <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (sync_out_s[i] == filt_r[i]) begin
                    filt_cnt_r[i] <= '0;
                end else if (filt_cnt_r[i] == FILT_LAST) begin
                    filt_r[i]     <= sync_out_s[i];
                    filt_cnt_r[i] <= '0;
                end else begin
                    filt_cnt_r[i] <= filt_cnt_r[i] + FW'(1);
                end
            end
        end
    end
`else
    // Without the filter the synchronised level is simply re-registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= '0;
        end else begin
            filt_r <= sync_out_s;
        end
    end
`endif

    // Delayed filtered level, reference for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_d_r <= '0;
        end else begin
            filt_d_r <= filt_r;
        end
    end

    assign data_filt = filt_r;
    assign pos_edge  = filt_r & ~filt_d_r;
    assign neg_edge  = ~filt_r & filt_d_r;

    // Mode qualification: bit 2i enables rising, bit 2i+1 enables falling.
    always_comb begin
        edge_pulse = '0;
        for (int i = 0; i < CH; i++) begin
            edge_pulse[i] = (pos_edge[i] & mode[2*i]) | (neg_edge[i] & mode[2*i+1]);
        end
    end

    assign any_edge = |edge_pulse;

    // Sticky flags and saturating counters; a same-cycle edge beats clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= '0;
            cnt_r    <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                sticky_r[i] <= edge_pulse[i] | (sticky_r[i] & ~clr[i]);
                if (clr[i]) begin
                    cnt_r[i] <= edge_pulse[i] ? CNT_W'(1) : '0;
                end else if (edge_pulse[i] && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    assign edge_sticky = sticky_r;
    assign edge_cnt    = cnt_r;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench for multi_edge_detect: stimulus queues expected edge events,
// a negedge monitor pops and compares them; works with or without MULTI_EDGE_GLITCH_FILTER_EN.
module tb_multi_edge_detect;

    localparam int CH    = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int CNT_W = 2;
`ifdef MULTI_EDGE_GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
    localparam int LAT     = SYNC + FILT;
`else
    localparam bit FILT_EN = 1'b0;
    localparam int LAT     = SYNC + 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [CH-1:0]        data_in;
    logic [2*CH-1:0]      mode;
    logic [CH-1:0]        clr;
    logic [CH-1:0]        data_filt, pos_edge, neg_edge, edge_pulse, edge_sticky;
    logic [CH*CNT_W-1:0]  edge_cnt;
    logic                 any_edge;

    typedef struct {
        int   ch;
        int   cyc;
        logic pos;
        logic pulse;
    } ev_t;

    ev_t evq[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    multi_edge_detect #(.CH(CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .clr(clr),
        .data_filt(data_filt), .pos_edge(pos_edge), .neg_edge(neg_edge),
        .edge_pulse(edge_pulse), .edge_sticky(edge_sticky), .edge_cnt(edge_cnt),
        .any_edge(any_edge)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed edge must match the oldest queued event of its channel.
    always @(negedge clk) begin
        logic exp_any;
        ev_t  e;
        int   k;
        exp_any = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (pos_edge[i] || neg_edge[i]) begin
                k = -1;
                for (int j = 0; j < evq.size(); j++) begin
                    if (k < 0 && evq[j].ch == i) k = j;
                end
                total++;
                if (k < 0) begin
                    bad++;
                    $display("FAIL unexpected_edge ch%0d cyc=%0d pos=%0b neg=%0b pulse=%0b, required none",
                             i, cyc, pos_edge[i], neg_edge[i], edge_pulse[i]);
                end else begin
                    e = evq[k];
                    evq.delete(k);
                    if (e.cyc != cyc || pos_edge[i] != e.pos || neg_edge[i] != !e.pos
                        || edge_pulse[i] != e.pulse) begin
                        bad++;
                        $display("FAIL edge_event ch%0d got cyc=%0d pos=%0b neg=%0b pulse=%0b, required cyc=%0d pos=%0b neg=%0b pulse=%0b",
                                 i, cyc, pos_edge[i], neg_edge[i], edge_pulse[i],
                                 e.cyc, e.pos, !e.pos, e.pulse);
                    end
                    exp_any = exp_any | e.pulse;
                end
            end
        end
        if (exp_any || any_edge) begin
            total++;
            if (any_edge !== exp_any) begin
                bad++;
                $display("FAIL any_edge cyc=%0d got=%0b required=%0b", cyc, any_edge, exp_any);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic val, input logic ev, input logic pulse);
        data_in[c] = val;
        if (ev) evq.push_back('{ch: c, cyc: cyc + LAT, pos: val, pulse: pulse});
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input int c);
        return int'(edge_cnt[c*CNT_W +: CNT_W]);
    endfunction

    initial begin
        rst_n   = 1'b0;
        data_in = '0;
        mode    = 8'hFF;
        clr     = '0;
        step(3);
        chk("reset_outputs", int'({data_filt, pos_edge, neg_edge, edge_pulse, edge_sticky, edge_cnt, any_edge}), 0);
        rst_n = 1'b1;
        step(2);

        // Basic rising edge on ch0, mode both.
        drive(0, 1'b1, 1'b1, 1'b1);
        step(LAT + 2);
        chk("ch0_filt", int'(data_filt[0]), 1);
        chk("ch0_cnt", cnt_of(0), 1);
        chk("ch0_sticky", int'(edge_sticky[0]), 1);

        // 3-cycle glitch on ch1 is dropped by the filter, 4-cycle pulse is accepted.
        drive(1, 1'b1, !FILT_EN, 1'b1);
        step(3);
        drive(1, 1'b0, !FILT_EN, 1'b1);
        step(LAT + 4);
        chk("ch1_glitch_filt", int'(data_filt[1]), 0);
        chk("ch1_glitch_cnt", cnt_of(1), FILT_EN ? 0 : 2);
        drive(1, 1'b1, 1'b1, 1'b1);
        step(4);
        drive(1, 1'b0, 1'b1, 1'b1);
        step(LAT + 4);
        chk("ch1_cnt", cnt_of(1), FILT_EN ? 2 : 3);
        chk("ch1_sticky", int'(edge_sticky[1]), 1);

        // ch2 rising-only mode, three square-wave periods, then mode off.
        mode[5:4] = 2'b01;
        for (int p = 0; p < 3; p++) begin
            drive(2, 1'b1, 1'b1, 1'b1);
            step(10);
            drive(2, 1'b0, 1'b1, 1'b0);
            step(10);
        end
        step(LAT);
        chk("ch2_cnt_rise", cnt_of(2), 3);
        chk("ch2_sticky", int'(edge_sticky[2]), 1);
        mode[5:4] = 2'b00;
        for (int p = 0; p < 3; p++) begin
            drive(2, 1'b1, 1'b1, 1'b0);
            step(10);
            drive(2, 1'b0, 1'b1, 1'b0);
            step(10);
        end
        step(LAT);
        chk("ch2_cnt_off", cnt_of(2), 3);

        // ch0 saturation, clr coinciding with an edge, then clr alone.
        mode[1:0] = 2'b01;
        for (int p = 0; p < 5; p++) begin
            drive(0, 1'b0, 1'b1, 1'b0);
            step(8);
            drive(0, 1'b1, 1'b1, 1'b1);
            step(8);
        end
        chk("ch0_saturated", cnt_of(0), 3);
        drive(0, 1'b0, 1'b1, 1'b0);
        step(8);
        drive(0, 1'b1, 1'b1, 1'b1);
        step(LAT);
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        chk("ch0_clr_edge_cnt", cnt_of(0), 1);
        chk("ch0_clr_edge_sticky", int'(edge_sticky[0]), 1);
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        chk("ch0_clr_cnt", cnt_of(0), 0);
        chk("ch0_clr_sticky", int'(edge_sticky[0]), 0);
        chk("ch2_cnt_kept", cnt_of(2), 3);

        // Reset asserted while the ch3 filter is part-way through counting.
        drive(3, 1'b1, !FILT_EN, 1'b1);
        step(4);
        rst_n   = 1'b0;
        data_in = '0;
        #1;
        chk("midreset_outputs", int'({data_filt, pos_edge, neg_edge, edge_pulse, edge_sticky, edge_cnt, any_edge}), 0);
        step(3);
        rst_n = 1'b1;
        step(LAT + 10);
        chk("post_reset_filt", int'(data_filt), 0);
        chk("post_reset_cnt", int'(edge_cnt), 0);

        // Single-cycle input pulse: passes only without the glitch filter.
        drive(0, 1'b1, !FILT_EN, 1'b1);
        step(1);
        drive(0, 1'b0, !FILT_EN, 1'b0);
        step(LAT + 4);
        chk("short_pulse_cnt", cnt_of(0), FILT_EN ? 0 : 1);

        step(5);
        chk("events_outstanding", evq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
